// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store to word-memory adapter with read-modify-write sub-word stores
// Optional macro LSU_MISALIGN_TRAP_EN: drop and flag misaligned halfword/word accesses.
module load_store_unit #(
  parameter int unsigned MEM_DEPTH = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misaligned_q, misaligned_d;

  logic        f3_ok, in_range, misaligned_req, drop;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data, merged;

  // Request classification, evaluated on the raw request while in IDLE.
  always_comb begin
    if (req_write) begin
      f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
              (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
    in_range = {2'b00, req_addr[31:2]} < MEM_DEPTH;
`ifdef LSU_MISALIGN_TRAP_EN
    case (req_funct3[1:0])
      2'b01:   misaligned_req = f3_ok && req_addr[0];
      2'b10:   misaligned_req = f3_ok && (req_addr[1:0] != 2'b00);
      default: misaligned_req = 1'b0;
    endcase
`else
    misaligned_req = 1'b0;
`endif
    drop = !f3_ok || !in_range || misaligned_req;
  end

  // Lane extraction for loads and lane replacement for sub-word stores.
  always_comb begin
    lane_b = mem_dout[{addr_q[1:0], 3'b000} +: 8];
    lane_h = mem_dout[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_data = {24'h0, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_data = {16'h0, lane_h};
      default: load_data = mem_dout;
    endcase
    merged = word_q;
    case (funct3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    word_d       = word_q;
    rdata_d      = rdata_q;
    misaligned_d = misaligned_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d      = req_write;
          funct3_d     = req_funct3;
          addr_d       = req_addr;
          wdata_d      = req_wdata;
          misaligned_d = misaligned_req;
          if (drop) begin
            rdata_d = 32'h0;
            state_d = RESP;
          end else if (req_write && (req_funct3 == 3'b010)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        word_d = mem_dout;
        if (!write_q) begin
          rdata_d = load_data;
          state_d = RESP;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        rdata_d = 32'h0;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      word_q       <= 32'h0;
      rdata_q      <= 32'h0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      word_q       <= word_d;
      rdata_q      <= rdata_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Gating with reset keeps a mid-operation reset from touching memory.
  assign req_ready       = reset && (state_q == IDLE);
  assign mem_read        = reset && (state_q == READ);
  assign mem_write       = reset && (state_q == WRITE);
  assign mem_addr        = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_din         = mem_write ? merged : 32'h0;
  assign resp_valid      = reset && (state_q == RESP);
  assign resp_rdata      = rdata_q;
  assign resp_misaligned = misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit against a byte-level reference
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam int unsigned DEPTH = 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_read, mem_write;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rdata;

  logic [31:0] dmem [DEPTH] = '{default: 32'h0};
  byte unsigned ref_b [int unsigned];

  always #5 clk = ~clk;

  load_store_unit #(.MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read),
    .mem_write(mem_write), .mem_dout(mem_dout)
  );

  assign mem_dout = (mem_read && mem_addr[31:16] == 16'h0) ? dmem[mem_addr[15:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write && mem_addr[31:16] == 16'h0) dmem[mem_addr[15:2]] <= mem_din;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rb(input int unsigned a);
    return ref_b.exists(a) ? 32'(ref_b[a]) : 32'h0;
  endfunction

  // Reference: memory as individual bytes, accesses computed from size/alignment arithmetic.
  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] er, output logic em,
                       output int el, output int erd, output int ewr);
    bit valid, inrange, mis;
    int size;
    int unsigned ea;
    logic [31:0] v;
    valid   = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    inrange = (a / 4) < DEPTH;
    mis     = TRAP && valid && (a % size != 0);
    ea      = a - (a % size);
    er = 32'h0; em = mis; erd = 0; ewr = 0;
    if (!valid || !inrange || mis) begin
      el = 1;
    end else if (w) begin
      for (int i = 0; i < size; i++) ref_b[ea + i] = wd[8*i +: 8];
      el = (size == 4) ? 2 : 3;
      erd = (size == 4) ? 0 : 1;
      ewr = 1;
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (rb(ea + i) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
      er = v; el = 2; erd = 1;
    end
  endtask

  task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    logic [31:0] er, gr;
    logic em, gm;
    int el, erd, ewr, lat, nrd, nwr, waited;
    string tag;
    tag = $sformatf("%s f3=%0d a=%h", w ? "st" : "ld", f3, a);
    model(w, f3, a, wd, er, em, el, erd, ewr);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, " ready"}, 32'(req_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; gr = 32'hX; gm = 1'bX;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      if (k > 1) @(negedge clk);
      nrd += int'(mem_read);
      nwr += int'(mem_write);
      if (resp_valid) begin
        lat = k; gr = resp_rdata; gm = resp_misaligned;
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(el));
    chk({tag, " rdata"}, gr, er);
    chk({tag, " misaligned"}, 32'(gm), 32'(em));
    chk({tag, " reads"}, 32'(nrd), 32'(erd));
    chk({tag, " writes"}, 32'(nwr), 32'(ewr));
    @(negedge clk);
    chk({tag, " pulse"}, 32'(resp_valid), 32'h0);
    chk({tag, " hold"}, resp_rdata, er);
    last_rdata = gr;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'h0);
    chk("rst resp_valid", 32'(resp_valid), 32'h0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst resp_mis", 32'(resp_misaligned), 32'h0);
    chk("rst mem_ctl", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_din", mem_din, 32'h0);
    reset = 1'b1;

    run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    run_op(1'b0, 3'b010, 32'h100, 32'h0);
    chk("t1 lw", last_rdata, 32'hDEADBEEF);

    run_op(1'b1, 3'b000, 32'h102, 32'h0000007F);
    run_op(1'b0, 3'b010, 32'h100, 32'h0);
    chk("t2 word", last_rdata, 32'hDE7FBEEF);
    run_op(1'b0, 3'b000, 32'h102, 32'h0);
    chk("t2 lb102", last_rdata, 32'h0000007F);
    run_op(1'b0, 3'b000, 32'h103, 32'h0);
    chk("t2 lb103", last_rdata, 32'hFFFFFFDE);
    run_op(1'b0, 3'b100, 32'h103, 32'h0);
    chk("t2 lbu103", last_rdata, 32'h000000DE);

    run_op(1'b1, 3'b010, 32'h104, 32'h0);
    run_op(1'b1, 3'b001, 32'h106, 32'h00008001);
    run_op(1'b0, 3'b010, 32'h104, 32'h0);
    chk("t3 word", last_rdata, 32'h80010000);
    run_op(1'b0, 3'b001, 32'h106, 32'h0);
    chk("t3 lh", last_rdata, 32'hFFFF8001);
    run_op(1'b0, 3'b101, 32'h106, 32'h0);
    chk("t3 lhu", last_rdata, 32'h00008001);

    run_op(1'b0, 3'b010, 32'h102, 32'h0);
    chk("t4 lw102", last_rdata, TRAP ? 32'h0 : 32'hDE7FBEEF);

    run_op(1'b0, 3'b011, 32'h100, 32'h0);
    run_op(1'b1, 3'b010, 32'h0001_0000, 32'h12345678);
    run_op(1'b0, 3'b010, 32'h0001_0000, 32'h0);
    chk("t5 oob load", last_rdata, 32'h0);

    // Reset while an SB is in its WRITE state.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h100; req_wdata = 32'h00000055;
    chk("t6 ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t6 read phase", 32'(mem_read), 32'h1);
    @(negedge clk);
    chk("t6 write phase", 32'(mem_write), 32'h1);
    reset = 1'b0;
    #1;
    chk("t6 write gated", 32'(mem_write), 32'h0);
    @(negedge clk);
    chk("t6 no resp", 32'(resp_valid), 32'h0);
    chk("t6 rdata reset", resp_rdata, 32'h0);
    reset = 1'b1;
    #1;
    chk("t6 ready after", 32'(req_ready), 32'h1);
    run_op(1'b0, 3'b010, 32'h100, 32'h0);
    chk("t6 word kept", last_rdata, 32'hDE7FBEEF);

    for (int n = 0; n < 80; n++) begin
      logic w;
      logic [2:0] f3;
      logic [31:0] a;
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'h100 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) a = 32'h0001_0000 + 32'($urandom_range(0, 15));
      run_op(w, f3, a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
